// File: rtl/psum_deskew_collector.sv
// Deskews the staggered bottom-row psums of the systolic array into aligned
// rows, then buffers them in a small FIFO drained over a valid/ready stream.
module psum_deskew_collector #(
   parameter int unsigned COLS                   = 4,
   parameter int unsigned ACCUMULATOR_DATA_WIDTH = 32,
   parameter int unsigned DEPTH                  = 4
) (
   input  logic                                   CLK,
   input  logic                                   SYNC_RST,
   input  logic                                   IN_VALID,
   input  logic [COLS*ACCUMULATOR_DATA_WIDTH-1:0] PSUM_IN,
   output logic                                   OUT_VALID,
   input  logic                                   OUT_READY,
   output logic [COLS*ACCUMULATOR_DATA_WIDTH-1:0] OUT_DATA,
   output logic [$clog2(DEPTH):0]                 COUNT,
   output logic                                   BUSY,
   output logic                                   OVERFLOW
);

   localparam int unsigned W  = ACCUMULATOR_DATA_WIDTH;
   localparam int unsigned RW = COLS * W;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic          wv;           // aligned row arrives at the FIFO this cycle
   logic          in_flight_d;  // next value of the OR of delayed-valid bits
   logic [RW-1:0] aligned;      // row with every lane lined up to column COLS-1

   // Valid delay line: COLS-1 free-running stages, none when COLS==1
   if (COLS > 1) begin : g_vld
      logic [COLS-2:0] vld_q;
      logic [COLS-2:0] vld_d;

      // Shift IN_VALID in at the bottom; the top bit is the write-valid
      always_comb begin
         vld_d = (vld_q << 1) | (COLS-1)'(IN_VALID);
      end

      // Delay-line register
      always_ff @(posedge CLK) begin
         if (SYNC_RST) vld_q <= '0;
         else          vld_q <= vld_d;
      end

      assign wv          = vld_q[COLS-2];
      assign in_flight_d = |vld_d;
   end else begin : g_novld
      assign wv          = IN_VALID;
      assign in_flight_d = 1'b0;
   end

   // Per-lane delay: lane k waits COLS-1-k cycles so all lanes meet lane COLS-1
   for (genvar k = 0; k < COLS; k++) begin : g_lane
      localparam int unsigned D = COLS - 1 - k;
      if (D == 0) begin : g_pass
         assign aligned[k*W +: W] = PSUM_IN[k*W +: W];
      end else begin : g_dly
         logic [W-1:0] pipe_q [D];

         // Lane shift register, no stall
         always_ff @(posedge CLK) begin
            if (SYNC_RST) begin
               for (int i = 0; i < int'(D); i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= PSUM_IN[k*W +: W];
               for (int i = 1; i < int'(D); i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign aligned[k*W +: W] = pipe_q[D-1];
      end
   end

   logic [RW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [RW-1:0] head_q, head_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          ovf_q, ovf_d;
   logic          rd_en, wr_en;

   // FIFO control and next-state of the registered output view
   always_comb begin
      rd_en    = valid_q && OUT_READY;
      wr_en    = wv && ((count_q < CW'(DEPTH)) || rd_en);
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      ovf_d   = ovf_q | (wv & ~wr_en);
      valid_d = (count_d != '0);
      busy_d  = in_flight_d | valid_d;
      // Head after this edge: the incoming row if the FIFO ends up holding
      // only it, otherwise the stored entry at the (possibly advanced) read pointer
      head_d  = '0;
      if (valid_d) begin
         if ((count_q == '0) || (rd_en && (count_q == CW'(1)))) head_d = aligned;
         else                                                   head_d = mem_q[rd_ptr_d];
      end
   end

   // FIFO storage, pointers and status registers
   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_en) mem_q[wr_ptr_q] <= aligned;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
      end
   end

   assign OUT_VALID = valid_q;
   assign OUT_DATA  = head_q;
   assign COUNT     = count_q;
   assign BUSY      = busy_q;
   assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_psum_deskew_collector.sv
// Bench for psum_deskew_collector: a directed vector table for a single row,
// scripted corner sequences, and random traffic against a row-level model.
module tb_psum_deskew_collector;

   localparam int unsigned COLS  = 4;
   localparam int unsigned W     = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned RW    = COLS * W;
   localparam int          MAXC  = 2000;

   logic          CLK;
   logic          SYNC_RST;
   logic          IN_VALID;
   logic [RW-1:0] PSUM_IN;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [RW-1:0] OUT_DATA;
   logic [2:0]    COUNT;
   logic          BUSY;
   logic          OVERFLOW;

   psum_deskew_collector #(
      .COLS(COLS), .ACCUMULATOR_DATA_WIDTH(W), .DEPTH(DEPTH)
   ) dut (
      .CLK(CLK), .SYNC_RST(SYNC_RST), .IN_VALID(IN_VALID), .PSUM_IN(PSUM_IN),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
      .COUNT(COUNT), .BUSY(BUSY), .OVERFLOW(OVERFLOW)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic          iv;
      logic [RW-1:0] din;
      logic          exp_v;
      logic [2:0]    exp_cnt;
      logic          exp_busy;
      logic [RW-1:0] exp_d;
   } vec_t;

   vec_t          tbl [7];
   int            n_cmp, n_bad;
   int            cyc;
   int            pops;
   bit            checking;
   bit            inj_v [MAXC];
   logic [RW-1:0] inj_d [MAXC];
   logic [RW-1:0] q [$];
   bit            m_ovf;

   function automatic logic [RW-1:0] mk(input int l3, input int l2, input int l1, input int l0);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [RW-1:0] rand_row();
      logic [RW-1:0] r;
      for (int k = 0; k < COLS; k++) r[k*W +: W] = W'($urandom);
      return r;
   endfunction

   task automatic cmp(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   // Compare every DUT output with the row-level model for the current cycle
   task automatic check_out();
      logic [RW-1:0] ed;
      bit            eb;
      if (!checking) return;
      ed = (q.size() != 0) ? q[0] : '0;
      eb = (q.size() != 0);
      for (int j = 1; j < COLS; j++)
         if (cyc - j >= 0 && inj_v[cyc-j]) eb = 1'b1;
      cmp("out_valid", RW'(OUT_VALID), RW'(q.size() != 0));
      cmp("out_data",  OUT_DATA,       ed);
      cmp("count",     RW'(COUNT),     RW'(q.size()));
      cmp("busy",      RW'(BUSY),      RW'(eb));
      cmp("overflow",  RW'(OVERFLOW),  RW'(m_ovf));
   endtask

   // One clock cycle: check, drive skewed lanes of injected rows, advance model
   task automatic step(input bit iv, input logic [RW-1:0] row, input bit rdy, input bit rst);
      logic [RW-1:0] din;
      bit            rd;
      int            a;
      check_out();
      inj_v[cyc] = iv && !rst;
      inj_d[cyc] = row;
      for (int k = 0; k < COLS; k++) begin
         if (cyc - k >= 0 && inj_v[cyc-k]) din[k*W +: W] = inj_d[cyc-k][k*W +: W];
         else                              din[k*W +: W] = W'($urandom);
      end
      SYNC_RST  = rst;
      IN_VALID  = iv;
      OUT_READY = rdy;
      PSUM_IN   = din;
      if (!rst && OUT_VALID === 1'b1 && rdy) pops++;
      @(posedge CLK);
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
         for (int j = 0; j < COLS; j++) if (cyc - j >= 0) inj_v[cyc-j] = 1'b0;
      end else begin
         rd = (q.size() != 0) && rdy;
         if (rd) void'(q.pop_front());
         a = cyc - (COLS - 1);
         if (a >= 0 && inj_v[a]) begin
            if (q.size() < DEPTH) q.push_back(inj_d[a]);
            else                  m_ovf = 1'b1;
         end
      end
      cyc++;
      @(negedge CLK);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0; pops = 0; checking = 0; m_ovf = 0;
      SYNC_RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; PSUM_IN = '0;

      // Single skewed row, lane k = 100+k presented at cycle k
      tbl[0] = '{1'b1, mk(0, 0, 0, 100), 1'b0, 3'd0, 1'b0, '0};
      tbl[1] = '{1'b0, mk(0, 0, 101, 0), 1'b0, 3'd0, 1'b1, '0};
      tbl[2] = '{1'b0, mk(0, 102, 0, 0), 1'b0, 3'd0, 1'b1, '0};
      tbl[3] = '{1'b0, mk(103, 0, 0, 0), 1'b0, 3'd0, 1'b1, '0};
      tbl[4] = '{1'b0, '0, 1'b1, 3'd1, 1'b1, mk(103, 102, 101, 100)};
      tbl[5] = '{1'b0, '0, 1'b0, 3'd0, 1'b0, '0};
      tbl[6] = '{1'b0, '0, 1'b0, 3'd0, 1'b0, '0};

      @(negedge CLK);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      checking = 1;

      for (int i = 0; i < 7; i++) begin
         cmp("tbl_valid", RW'(OUT_VALID), RW'(tbl[i].exp_v));
         cmp("tbl_count", RW'(COUNT),     RW'(tbl[i].exp_cnt));
         cmp("tbl_busy",  RW'(BUSY),      RW'(tbl[i].exp_busy));
         cmp("tbl_data",  OUT_DATA,       tbl[i].exp_d);
         cmp("tbl_ovf",   RW'(OVERFLOW),  '0);
         SYNC_RST = 1'b0; IN_VALID = tbl[i].iv; OUT_READY = 1'b1; PSUM_IN = tbl[i].din;
         inj_v[cyc] = 1'b0;
         @(posedge CLK);
         cyc++;
         @(negedge CLK);
      end

      // Five back-to-back rows with negative lanes, always ready
      pops = 0;
      for (int r = 0; r < 5; r++) step(1'b1, mk(16*r+3, 16*r+2, 16*r+1, -5-r), 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
      cmp("burst5_pops", RW'(pops), RW'(5));

      // Six rows into a stalled FIFO: two dropped, overflow sticks
      pops = 0;
      for (int r = 0; r < 6; r++) step(1'b1, rand_row(), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
      cmp("ovf_pops", RW'(pops), RW'(4));
      cmp("ovf_sticky", RW'(OVERFLOW), RW'(1));
      step(1'b0, '0, 1'b0, 1'b1);

      // Full FIFO with simultaneous read and write, pointers wrap many times
      pops = 0;
      for (int r = 0; r < 4; r++) step(1'b1, rand_row(), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
      cmp("full_count", RW'(COUNT), RW'(4));
      for (int r = 0; r < 12; r++) step(1'b1, rand_row(), (r >= 3), 1'b0);
      cmp("full_rw_count", RW'(COUNT), RW'(4));
      for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0);
      cmp("full_pops", RW'(pops), RW'(16));
      cmp("full_no_ovf", RW'(OVERFLOW), RW'(0));

      // Reset with two rows in the deskew stage and two in the FIFO
      pops = 0;
      for (int r = 0; r < 2; r++) step(1'b1, rand_row(), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
      step(1'b1, rand_row(), 1'b0, 1'b0);
      step(1'b1, rand_row(), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      cmp("rst_busy", RW'(BUSY), RW'(0));
      cmp("rst_count", RW'(COUNT), RW'(0));
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
      cmp("rst_no_stale", RW'(pops), RW'(0));

      // Toggling ready during a six-row burst
      pops = 0;
      for (int r = 0; r < 6; r++) step(1'b1, rand_row(), (r % 2 == 0), 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, '0, (i % 2 == 0), 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
      cmp("toggle_pops", RW'(pops), RW'(6));

      // Random traffic, occasional resets, then a low-ready phase to force drops
      for (int i = 0; i < 300; i++)
         step(($urandom % 3) != 0, rand_row(), ($urandom % 4) != 0, ($urandom % 100) == 0);
      for (int i = 0; i < 200; i++)
         step(($urandom % 3) != 0, rand_row(), ($urandom % 10) < 3, ($urandom % 150) == 0);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
